// File: rtl/frame_color_scaler.sv
// Streams an IMG_W x IMG_H frame from RAM at one pixel per clock, scales R/G/B by
// Q1.8 gains with saturation, optionally mirrors each line, and writes the result back.
module frame_color_scaler #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 320,
  parameter int RD_OFFSET = 0,
  parameter int WR_OFFSET = 102400,
  parameter int RD_LAT    = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mirror,
  input  logic [8:0]        gain_r,
  input  logic [8:0]        gain_g,
  input  logic [8:0]        gain_b,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              mirror_q, mirror_d;
  logic [8:0]        gainR_q, gainR_d, gainG_q, gainG_d, gainB_q, gainB_d;

  logic [RD_LAT-1:0] vld_q;
  logic [XW-1:0]     px_q [RD_LAT];
  logic [YW-1:0]     py_q [RD_LAT];

  logic              wr_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [31:0]       wrData_q;
  logic              err_q;
  logic [XW-1:0]     outCol;
  logic              unused_rdTopByte;

  function automatic logic [7:0] scaleChan(input logic [7:0] c, input logic [8:0] g);
    logic [16:0] p;
    p = {9'b0, c} * {8'b0, g};
    return p[16] ? 8'hFF : p[15:8];
  endfunction

  // Frame sequencing: a start is accepted in IDLE and also in the DONE cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    mirror_d = mirror_q;
    gainR_d  = gainR_q;
    gainG_d  = gainG_q;
    gainB_d  = gainB_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          mirror_d = mirror;
          gainR_d  = gain_r;
          gainG_d  = gain_g;
          gainB_d  = gain_b;
          idx_d    = '0;
          x_d      = '0;
          y_d      = '0;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (wr_q && (vld_q == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mirror_q <= 1'b0;
      gainR_q  <= '0;
      gainG_q  <= '0;
      gainB_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mirror_q <= mirror_d;
      gainR_q  <= gainR_d;
      gainG_q  <= gainG_d;
      gainB_q  <= gainB_d;
    end
  end

  // Reads in flight carry their pixel coordinates until the RAM data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == RUN);
      px_q[0]  <= x_q;
      py_q[0]  <= y_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
    end
  end

  assign outCol = mirror_q ? (X_LAST - px_q[RD_LAT-1]) : px_q[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_q  <= vld_q[RD_LAT-1];
      err_q <= start && busy;
      if (vld_q[RD_LAT-1]) begin
        wrAddr_q <= ADDR_W'(WR_OFFSET)
                  + ADDR_W'(py_q[RD_LAT-1]) * ADDR_W'(IMG_W)
                  + ADDR_W'(outCol);
        wrData_q <= {8'h00,
                     scaleChan(mem_rd_data[23:16], gainR_q),
                     scaleChan(mem_rd_data[15:8],  gainG_q),
                     scaleChan(mem_rd_data[7:0],   gainB_q)};
      end
    end
  end

  assign unused_rdTopByte = ^mem_rd_data[31:24];

  assign mem_rd      = (state_q == RUN);
  assign mem_rd_addr = ADDR_W'(RD_OFFSET) + idx_q;
  assign mem_wr      = wr_q;
  assign mem_wr_addr = wrAddr_q;
  assign mem_wr_data = wrData_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_frame_color_scaler.sv
// Directed and randomized frames on a 4x2 image; writes are compared against an
// arithmetic model of gain, saturation and mirroring.
module tb_frame_color_scaler;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int N    = W * H;
  localparam int LAT  = 2;
  localparam int WOFF = 100;
  localparam int LOGN = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mirror = 1'b0;
  logic [8:0]  gain_r = '0, gain_g = '0, gain_b = '0;
  logic        mem_rd, mem_wr, busy, done, err;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;

  frame_color_scaler #(
    .IMG_W(W), .IMG_H(H), .RD_OFFSET(0), .WR_OFFSET(WOFF), .RD_LAT(LAT), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mirror(mirror),
    .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM with a two-cycle read latency.
  logic [31:0] srcMem [N];
  logic [31:0] rdA1 = '0, rdA2 = '0;
  always @(posedge clk) begin
    rdA1 <= mem_rd_addr;
    rdA2 <= rdA1;
  end
  assign mem_rd_data = srcMem[rdA2[2:0]];

  logic [31:0] wrAddrLog [LOGN];
  logic [31:0] wrDataLog [LOGN];
  int          wrCycLog  [LOGN];
  logic [31:0] rdAddrLog [LOGN];
  int          rdCycLog  [LOGN];
  int   wrN = 0, rdN = 0, doneN = 0, doneCyc = 0, errN = 0, errCyc = 0;
  logic busyAtDone = 1'b0;

  always @(negedge clk) begin
    if (mem_rd && rdN < LOGN) begin
      rdAddrLog[rdN] = mem_rd_addr;
      rdCycLog[rdN]  = cyc;
      rdN++;
    end
    if (mem_wr && wrN < LOGN) begin
      wrAddrLog[wrN] = mem_wr_addr;
      wrDataLog[wrN] = mem_wr_data;
      wrCycLog[wrN]  = cyc;
      wrN++;
    end
    if (done) begin
      doneN++;
      doneCyc    = cyc;
      busyAtDone = busy;
    end
    if (err) begin
      errN++;
      errCyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;
  int base = 0;
  int curGr, curGg, curGb;
  bit curMir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refPixel(input logic [31:0] w, input int gr, input int gg, input int gb);
    int r, g, b;
    r = int'(w[23:16]) * gr / 256;
    g = int'(w[15:8])  * gg / 256;
    b = int'(w[7:0])   * gb / 256;
    if (r > 255) r = 255;
    if (g > 255) g = 255;
    if (b > 255) b = 255;
    return {8'h00, r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic int refAddr(input int k, input bit mir);
    int x, y;
    x = k % W;
    y = k / W;
    return WOFF + y * W + (mir ? (W - 1 - x) : x);
  endfunction

  task automatic advanceTo(input int c);
    while (cyc - base < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues a one-cycle start, then scrambles the sampled inputs to prove they were latched.
  task automatic applyStimulus(input bit mir, input int gr, input int gg, input int gb);
    mirror = mir;
    gain_r = 9'(gr);
    gain_g = 9'(gg);
    gain_b = 9'(gb);
    curMir = mir;
    curGr  = gr;
    curGg  = gg;
    curGb  = gb;
    base   = cyc;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mirror = ~mir;
    gain_r = 9'($urandom);
    gain_g = 9'($urandom);
    gain_b = 9'($urandom);
  endtask

  task automatic checkOutput(input int fb, input int w0, input int r0, input string name);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s rdAddr[%0d]", name, k), rdAddrLog[r0+k], 32'(k));
      check($sformatf("%s rdCyc[%0d]", name, k), 32'(rdCycLog[r0+k]), 32'(fb + 1 + k));
      check($sformatf("%s wrAddr[%0d]", name, k), wrAddrLog[w0+k], 32'(refAddr(k, curMir)));
      check($sformatf("%s wrData[%0d]", name, k), wrDataLog[w0+k],
            refPixel(srcMem[k], curGr, curGg, curGb));
      check($sformatf("%s wrCyc[%0d]", name, k), 32'(wrCycLog[w0+k]), 32'(fb + 2 + k + LAT));
    end
  endtask

  task automatic runFrame(input bit mir, input int gr, input int gg, input int gb, input string name);
    int w0, r0, d0, e0;
    w0 = wrN;
    r0 = rdN;
    d0 = doneN;
    e0 = errN;
    applyStimulus(mir, gr, gg, gb);
    advanceTo(16);
    checkOutput(base, w0, r0, name);
    check({name, " wrCount"}, 32'(wrN - w0), 32'(N));
    check({name, " doneCount"}, 32'(doneN - d0), 32'd1);
    check({name, " doneCyc"}, 32'(doneCyc), 32'(base + 2 + N + LAT));
    check({name, " busyAtDone"}, {31'b0, busyAtDone}, 32'd0);
    check({name, " noErr"}, 32'(errN - e0), 32'd0);
    check({name, " rdAddrHold"}, mem_rd_addr, 32'(N - 1));
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++) srcMem[i] = $urandom;
  endtask

  initial begin
    int w0, r0, d0, e0, b1;
    for (int i = 0; i < N; i++) srcMem[i] = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    check("rst rdAddr", mem_rd_addr, 32'd0);
    check("rst wrAddr", mem_wr_addr, 32'd0);
    check("rst wrData", mem_wr_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] passthrough");
    for (int i = 0; i < N; i++) srcMem[i] = 32'h00C86432 + 32'(i);
    runFrame(1'b0, 256, 256, 256, "pass");

    $display("[TB] halving");
    for (int i = 0; i < N; i++) srcMem[i] = 32'hFFC86432;
    runFrame(1'b0, 128, 128, 128, "half");
    check("half word", wrDataLog[wrN-1], 32'h00643219);

    $display("[TB] saturation");
    for (int i = 0; i < N; i++) srcMem[i] = 32'h00FF80FF;
    runFrame(1'b0, 511, 0, 257, "sat");
    check("sat word", wrDataLog[wrN-1], 32'h00FF00FF);

    $display("[TB] mirror");
    fillRandom();
    runFrame(1'b1, 256, 256, 256, "mirror");
    check("mirror idx0", wrAddrLog[wrN-8], 32'd103);
    check("mirror idx3", wrAddrLog[wrN-5], 32'd100);
    check("mirror idx4", wrAddrLog[wrN-4], 32'd107);
    check("mirror idx7", wrAddrLog[wrN-1], 32'd104);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      fillRandom();
      runFrame(1'($urandom), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 511)), $sformatf("rand%0d", f));
    end

    $display("[TB] start while busy");
    fillRandom();
    w0 = wrN;
    r0 = rdN;
    d0 = doneN;
    e0 = errN;
    applyStimulus(1'b1, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 511)));
    b1 = base;
    advanceTo(5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    advanceTo(7);
    check("busy errCount", 32'(errN - e0), 32'd1);
    check("busy errCyc", 32'(errCyc), 32'(b1 + 6));
    advanceTo(12);
    applyStimulus(curMir, curGr, curGg, curGb);
    check("busy f1 doneCount", 32'(doneN - d0), 32'd1);
    check("busy f1 doneCyc", 32'(doneCyc), 32'(b1 + 12));
    check("busy f1 busyAtDone", {31'b0, busyAtDone}, 32'd0);
    check("busy f1 wrCount", 32'(wrN - w0), 32'(N));
    advanceTo(16);
    check("busy restart noErr", 32'(errN - e0), 32'd1);
    checkOutput(b1, w0, r0, "busyF1");
    checkOutput(base, w0 + N, r0 + N, "busyF2");
    check("busy f2 wrCount", 32'(wrN - w0), 32'(2 * N));
    check("busy f2 doneCyc", 32'(doneCyc), 32'(base + 2 + N + LAT));

    $display("[TB] reset mid-frame");
    fillRandom();
    r0 = rdN;
    w0 = wrN;
    applyStimulus(1'b0, 256, 256, 256);
    advanceTo(6);
    rst_n = 1'b0;
    advanceTo(7);
    check("midrst mem_rd", {31'b0, mem_rd}, 32'd0);
    check("midrst mem_wr", {31'b0, mem_wr}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst rdCount", 32'(rdN - r0), 32'd5);
    check("midrst wrCount", 32'(wrN - w0), 32'd2);
    r0 = rdN;
    w0 = wrN;
    d0 = doneN;
    advanceTo(8);
    rst_n = 1'b1;
    advanceTo(20);
    check("postrst noRead", 32'(rdN - r0), 32'd0);
    check("postrst noWrite", 32'(wrN - w0), 32'd0);
    check("postrst noDone", 32'(doneN - d0), 32'd0);
    check("postrst busy", {31'b0, busy}, 32'd0);
    fillRandom();
    runFrame(1'b1, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
             int'($urandom_range(0, 511)), "afterRst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_color_scaler.md
# frame_color_scaler

Frame-level pixel processor that sits between the frame-buffer RAM read and write ports in the image pipeline. It reads a full IMG_W x IMG_H frame at one pixel per clock and applies an independent fixed-point gain with saturation to each of the R, G and B channels. It can optionally mirror the frame horizontally, and writes the result to a second frame region. It is the parametrised successor to the fixed 320x320, four-cycles-per-pixel colour-removal path.

## Interface
Parameters:
- IMG_W, 320, pixels per line (>=2).
- IMG_H, 320, lines per frame (>=1).
- RD_OFFSET, 0, base word address of the source frame.
- WR_OFFSET, 102400, base word address of the destination frame.
- RD_LAT, 2, RAM read latency in cycles (>=1).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start request.
- mirror  in  1  horizontal mirror enable; sampled on accepted start.
- gain_r, gain_g, gain_b  in  9 each  Q1.8 gains (256 = 1.0); sampled on accepted start.
- mem_rd  out  1  read strobe.
- mem_rd_addr  out  ADDR_W  read word address.
- mem_rd_data  in  32  read data; byte 2 = R, byte 1 = G, byte 0 = B, byte 3 ignored.
- mem_wr  out  1  write strobe.
- mem_wr_addr  out  ADDR_W  write word address.
- mem_wr_data  out  32  write data, same byte layout; byte 3 always 0.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame is complete.
- err  out  1  one-cycle pulse when start arrives while busy.

## Operation
- States:
  - IDLE: on start, latch gains and mirror, clear x/y/index, go to RUN.
  - RUN: issue one read per cycle. After the read for index N-1 (N = IMG_W*IMG_H), go to DRAIN.
  - DRAIN: wait until the last write has been issued, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Read address: RD_OFFSET + index, where index runs 0..N-1. x wraps at IMG_W-1 and increments y on wrap.
- A valid shift register of depth RD_LAT tracks reads in flight, together with the (x,y) of each pixel. Data returns RD_LAT cycles after its mem_rd.
- Scale, per channel: p = c * gain (17-bit product), out = (p >> 8) saturated to 255 (truncating, no rounding).
- Write address:
  - mirror = 0: WR_OFFSET + y*IMG_W + x.
  - mirror = 1: WR_OFFSET + y*IMG_W + (IMG_W-1-x).
- start while busy is ignored and pulses err. The in-progress frame is unaffected.
- start in IDLE while err logic is idle: no err pulse.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately; no further reads or writes are issued and done does not pulse.

## Timing
- start accepted at edge 0. mem_rd is high with address RD_OFFSET + k in cycle 1+k, for k = 0..N-1. There are no gaps in the read stream.
- Pixel k is written in cycle 2+k+RD_LAT; mem_wr is high for N consecutive cycles.
- busy is high from cycle 1 through cycle 1+N+RD_LAT (the last write).
- done is high in cycle 2+N+RD_LAT, with busy low.
- A new start is accepted in the cycle done is high, or later. A start in the done cycle is not an error.
- mem_wr_addr and mem_wr_data are valid only while mem_wr is high. The read address holds its last value otherwise.
- err asserts in the cycle after the offending start.

## Test plan
All scenarios use IMG_W=4, IMG_H=2, RD_LAT=2, RD_OFFSET=0, WR_OFFSET=100.
- Passthrough: gains all 256, mirror=0, source word k = 0x00C86432+k.
  - Expected: 8 writes to addresses 100..107 with identical words.
  - Expected: first write in cycle 4, done in cycle 12.
- Halving: gains all 128, word 0xFFC86432.
  - Expected: written word 0x00643219 (byte 3 cleared).
- Saturation: gain_r=511, gain_g=0, gain_b=257, word 0x00FF80FF.
  - Expected: 0x00FF00FF.
- Mirror: mirror=1, identity gains.
  - Expected: read index 0 is written at address 103; index 3 at 100; index 4 at 107; index 7 at 104.
- Start while busy: second start in cycle 5.
  - Expected: err high in cycle 6; write count stays 8; done still in cycle 12.
  - Expected: a start in cycle 12 begins a new frame without err.
- Reset mid-frame: rst_n low in cycle 6, released in cycle 8.
  - Expected: mem_rd, mem_wr, busy and done are 0 from the reset edge onward, and state is IDLE.
  - Expected: a subsequent start runs a complete, correct frame.
